// File: rtl/branch_target_buffer_pkg.sv
// Shared defaults and write-decode type for the fully-associative branch target buffer.
package branch_target_buffer_pkg;

    localparam int unsigned BTB_ADDR_WIDTH = 32;
    localparam int unsigned BTB_DEPTH      = 32;
    localparam int unsigned BTB_DEPTH_LOG2 = 5;

    // What a resolved-branch write does to the table this cycle.
    typedef enum logic [1:0] {
        WrNone   = 2'd0,
        WrUpdate = 2'd1,
        WrAlloc  = 2'd2
    } wr_op_e;

endpackage

// File: rtl/branch_target_buffer_priority_encoder.sv
// Lowest-set-bit priority encoder with an any-set flag.
module priority_encoder #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned WIDTH_LOG2 = 5
) (
    input  logic [WIDTH-1:0]      i_req,
    output logic [WIDTH_LOG2-1:0] o_idx,
    output logic                  o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_req;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = WIDTH_LOG2'(i);
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Fully-associative branch target buffer: combinational fetch lookup, resolve-stage update
// with saturating direction counters, invalid-first then round-robin replacement.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BTB_ADDR_WIDTH,
    parameter int unsigned DEPTH      = BTB_DEPTH,
    parameter int unsigned DEPTH_LOG2 = BTB_DEPTH_LOG2,
    parameter int unsigned CTR_WIDTH  = 2,
    parameter int unsigned ALLOC_NT   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,        // asynchronous, active low
    input  logic                  i_flush,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_write_key,
    input  logic [ADDR_WIDTH-1:0] i_write_val,
    input  logic                  i_write_taken,
    input  logic [ADDR_WIDTH-1:0] i_read_key,
    output logic [ADDR_WIDTH-1:0] o_read_val,
    output logic                  o_read_valid,
    output logic                  o_read_hit,
    output logic [DEPTH_LOG2:0]   o_occupancy
);

    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

    logic [DEPTH-1:0]      r_valid;
    logic [ADDR_WIDTH-1:0] r_key [DEPTH];
    logic [ADDR_WIDTH-1:0] r_val [DEPTH];
    logic [CTR_WIDTH-1:0]  r_ctr [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rr_ptr;
    logic [DEPTH_LOG2:0]   r_occupancy;

    logic [DEPTH-1:0]      w_rd_match;
    logic [DEPTH-1:0]      w_wr_match;
    logic [DEPTH-1:0]      w_invalid;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic [DEPTH_LOG2-1:0] w_inv_idx;
    logic                  w_rd_any;
    logic                  w_wr_any;
    logic                  w_inv_any;
    logic [DEPTH_LOG2-1:0] w_victim;
    logic [CTR_WIDTH-1:0]  w_ctr_cur;
    logic [CTR_WIDTH-1:0]  w_ctr_next;
    wr_op_e                w_op;

    // A valid entry matches regardless of its counter value.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_rd_match[i] = r_valid[i] && (r_key[i] == i_read_key);
            w_wr_match[i] = r_valid[i] && (r_key[i] == i_write_key);
        end
    end

    assign w_invalid = ~r_valid;

    priority_encoder #(
        .WIDTH      (DEPTH),
        .WIDTH_LOG2 (DEPTH_LOG2)
    ) u_rd_enc (
        .i_req (w_rd_match),
        .o_idx (w_rd_idx),
        .o_any (w_rd_any)
    );

    priority_encoder #(
        .WIDTH      (DEPTH),
        .WIDTH_LOG2 (DEPTH_LOG2)
    ) u_wr_enc (
        .i_req (w_wr_match),
        .o_idx (w_wr_idx),
        .o_any (w_wr_any)
    );

    priority_encoder #(
        .WIDTH      (DEPTH),
        .WIDTH_LOG2 (DEPTH_LOG2)
    ) u_inv_enc (
        .i_req (w_invalid),
        .o_idx (w_inv_idx),
        .o_any (w_inv_any)
    );

    assign o_read_hit   = w_rd_any;
    assign o_read_val   = w_rd_any ? r_val[w_rd_idx] : '0;
    assign o_read_valid = w_rd_any & r_ctr[w_rd_idx][CTR_WIDTH-1];
    assign o_occupancy  = r_occupancy;

    always_comb begin
        w_op = WrNone;
        if (i_write && !i_flush) begin
            if (w_wr_any) begin
                w_op = WrUpdate;
            end else if (i_write_taken || (ALLOC_NT != 0)) begin
                w_op = WrAlloc;
            end
        end
    end

    assign w_victim  = w_inv_any ? w_inv_idx : r_rr_ptr;
    assign w_ctr_cur = r_ctr[w_wr_idx];

    // Saturating counter step; explicit end checks so the value never wraps.
    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (i_write_taken) begin
            if (w_ctr_cur != CTR_MAX) begin
                w_ctr_next = w_ctr_cur + CTR_WIDTH'(1);
            end
        end else if (w_ctr_cur != '0) begin
            w_ctr_next = w_ctr_cur - CTR_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_valid     <= '0;
            r_rr_ptr    <= '0;
            r_occupancy <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_key[i] <= '0;
                r_val[i] <= '0;
                r_ctr[i] <= '0;
            end
        end else if (i_flush) begin
            r_valid     <= '0;
            r_rr_ptr    <= '0;
            r_occupancy <= '0;
        end else begin
            case (w_op)
                WrUpdate: begin
                    r_ctr[w_wr_idx] <= w_ctr_next;
                    if (i_write_taken) begin
                        r_val[w_wr_idx] <= i_write_val;
                    end
                end
                WrAlloc: begin
                    r_valid[w_victim] <= 1'b1;
                    r_key[w_victim]   <= i_write_key;
                    r_val[w_victim]   <= i_write_val;
                    r_ctr[w_victim]   <= i_write_taken ? CTR_MAX : '0;
                    // Filling a free slot grows occupancy; evicting advances the pointer.
                    if (w_inv_any) begin
                        r_occupancy <= r_occupancy + (DEPTH_LOG2 + 1)'(1);
                    end else begin
                        r_rr_ptr <= r_rr_ptr + DEPTH_LOG2'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: two 4-entry instances (not-taken allocation off/on) driven
// in lockstep and compared every cycle against a table model, plus literal scenario checks.
module tb_branch_target_buffer;

    localparam int DEPTH = 4;
    localparam int CTR_W = 2;
    localparam int CMAX  = (1 << CTR_W) - 1;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        wr;
    logic        wtaken;
    logic [31:0] wkey;
    logic [31:0] wval;
    logic [31:0] rkey;

    logic [31:0] dval   [2];
    logic        dvalid [2];
    logic        dhit   [2];
    logic [2:0]  docc   [2];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Reference table: index 0 drops not-taken misses, index 1 allocates them.
    bit          m_valid [2][DEPTH];
    logic [31:0] m_key   [2][DEPTH];
    logic [31:0] m_val   [2][DEPTH];
    int          m_ctr   [2][DEPTH];
    int          m_rr    [2];

    branch_target_buffer #(
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (2),
        .CTR_WIDTH  (CTR_W),
        .ALLOC_NT   (0)
    ) u_dut0 (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_flush       (flush),
        .i_write       (wr),
        .i_write_key   (wkey),
        .i_write_val   (wval),
        .i_write_taken (wtaken),
        .i_read_key    (rkey),
        .o_read_val    (dval[0]),
        .o_read_valid  (dvalid[0]),
        .o_read_hit    (dhit[0]),
        .o_occupancy   (docc[0])
    );

    branch_target_buffer #(
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (2),
        .CTR_WIDTH  (CTR_W),
        .ALLOC_NT   (1)
    ) u_dut1 (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_flush       (flush),
        .i_write       (wr),
        .i_write_key   (wkey),
        .i_write_val   (wval),
        .i_write_taken (wtaken),
        .i_read_key    (rkey),
        .o_read_val    (dval[1]),
        .o_read_valid  (dvalid[1]),
        .o_read_hit    (dhit[1]),
        .o_occupancy   (docc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_rr[d] = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[d][i] = 1'b0;
                m_key[d][i]   = '0;
                m_val[d][i]   = '0;
                m_ctr[d][i]   = 0;
            end
        end
    endtask

    function automatic int model_count(input int d);
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_valid[d][i]);
        return n;
    endfunction

    function automatic void model_read(input int d, input logic [31:0] k, output bit hit,
                                       output bit vld, output logic [31:0] val);
        hit = 1'b0;
        vld = 1'b0;
        val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && m_valid[d][i] && m_key[d][i] == k) begin
                hit = 1'b1;
                vld = (m_ctr[d][i] >= (1 << (CTR_W - 1)));
                val = m_val[d][i];
            end
        end
    endfunction

    // Applies the inputs present at a rising edge to the reference table.
    task automatic model_step();
        int hit_i;
        int slot;
        if (!rst) return;
        for (int d = 0; d < 2; d++) begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) m_valid[d][i] = 1'b0;
                m_rr[d] = 0;
            end else if (wr) begin
                hit_i = -1;
                for (int i = 0; i < DEPTH; i++)
                    if (hit_i < 0 && m_valid[d][i] && m_key[d][i] == wkey) hit_i = i;
                if (hit_i >= 0) begin
                    if (wtaken) begin
                        m_ctr[d][hit_i] = (m_ctr[d][hit_i] < CMAX) ? m_ctr[d][hit_i] + 1 : CMAX;
                        m_val[d][hit_i] = wval;
                    end else begin
                        m_ctr[d][hit_i] = (m_ctr[d][hit_i] > 0) ? m_ctr[d][hit_i] - 1 : 0;
                    end
                end else if (wtaken || d == 1) begin
                    slot = -1;
                    for (int i = 0; i < DEPTH; i++)
                        if (slot < 0 && !m_valid[d][i]) slot = i;
                    if (slot < 0) begin
                        slot    = m_rr[d];
                        m_rr[d] = (m_rr[d] + 1) % DEPTH;
                    end
                    m_valid[d][slot] = 1'b1;
                    m_key[d][slot]   = wkey;
                    m_val[d][slot]   = wval;
                    m_ctr[d][slot]   = wtaken ? CMAX : 0;
                end
            end
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        bit          eh;
        bit          ev;
        logic [31:0] eval;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                model_read(d, rkey, eh, ev, eval);
                check("model_hit", d, 32'(dhit[d]), 32'(eh));
                check("model_valid", d, 32'(dvalid[d]), 32'(ev));
                check("model_val", d, dval[d], eval);
                check("model_occ", d, 32'(docc[d]), 32'(model_count(d)));
            end
        end
    end

    task automatic drive(input bit w, input logic [31:0] k, input logic [31:0] v,
                         input bit t, input logic [31:0] rk);
        wr     = w;
        wkey   = k;
        wval   = v;
        wtaken = t;
        rkey   = rk;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic lit_read(input string name, input int d, input bit hit, input bit vld,
                            input logic [31:0] val, input int occ);
        check({name, "_hit"}, d, 32'(dhit[d]), 32'(hit));
        check({name, "_valid"}, d, 32'(dvalid[d]), 32'(vld));
        check({name, "_val"}, d, dval[d], val);
        check({name, "_occ"}, d, 32'(docc[d]), 32'(occ));
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        drive(0, '0, '0, 0, 32'h100);
        model_clear();
        #3;
        lit_read("reset", 0, 0, 0, 32'h0, 0);
        lit_read("reset", 1, 0, 0, 32'h0, 0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;

        // First taken write: invisible in its own cycle, visible next cycle.
        drive(1, 32'h100, 32'h200, 1, 32'h100);
        @(negedge clk);
        check("same_cycle_hit", 0, 32'(dhit[0]), 32'h0);
        tick();
        drive(0, '0, '0, 0, 32'h100);
        @(negedge clk);
        lit_read("alloc", 0, 1, 1, 32'h200, 1);
        tick();

        // Hysteresis: 3 -> 2 -> 1 clears the prediction but keeps the entry.
        drive(1, 32'h100, 32'h999, 0, 32'h100);
        tick();
        tick();
        drive(0, '0, '0, 0, 32'h100);
        @(negedge clk);
        lit_read("hyst_nt", 0, 1, 0, 32'h200, 1);
        tick();
        drive(1, 32'h100, 32'h300, 1, 32'h100);
        tick();
        drive(0, '0, '0, 0, 32'h100);
        @(negedge clk);
        lit_read("hyst_t", 0, 1, 1, 32'h300, 1);
        tick();

        // Not-taken miss: dropped by instance 0, allocated strong-not-taken by instance 1.
        drive(1, 32'h400, 32'h444, 0, 32'h400);
        tick();
        drive(0, '0, '0, 0, 32'h400);
        @(negedge clk);
        lit_read("nt_drop", 0, 0, 0, 32'h0, 1);
        lit_read("nt_alloc", 1, 1, 0, 32'h444, 2);
        tick();

        // Fill instance 0 (0x100 already in slot 0), then evict round-robin.
        for (int k = 1; k < 4; k++) begin
            drive(1, 32'h100 + 32'(k) * 32'h10, 32'h1100 + 32'(k) * 32'h10, 1, 32'h0);
            tick();
        end
        drive(0, '0, '0, 0, 32'h130);
        @(negedge clk);
        lit_read("full", 0, 1, 1, 32'h1130, 4);
        tick();
        drive(1, 32'h140, 32'h1140, 1, 32'h0);
        tick();
        drive(1, 32'h150, 32'h1150, 1, 32'h0);
        tick();
        drive(0, '0, '0, 0, 32'h100);
        @(negedge clk);
        lit_read("evict_a", 0, 0, 0, 32'h0, 4);
        tick();
        rkey = 32'h110;
        @(negedge clk);
        lit_read("evict_b", 0, 0, 0, 32'h0, 4);
        tick();
        rkey = 32'h140;
        @(negedge clk);
        lit_read("keep_e", 0, 1, 1, 32'h1140, 4);
        tick();
        rkey = 32'h150;
        @(negedge clk);
        lit_read("keep_f", 0, 1, 1, 32'h1150, 4);
        tick();
        rkey = 32'h120;
        @(negedge clk);
        lit_read("keep_c", 0, 1, 1, 32'h1120, 4);
        tick();

        // Flush beats a coincident write.
        flush = 1'b1;
        drive(1, 32'h500, 32'h555, 1, 32'h500);
        tick();
        flush = 1'b0;
        drive(0, '0, '0, 0, 32'h500);
        @(negedge clk);
        lit_read("flush", 0, 0, 0, 32'h0, 0);
        lit_read("flush", 1, 0, 0, 32'h0, 0);
        tick();
        drive(1, 32'h600, 32'h666, 1, 32'h0);
        tick();
        drive(0, '0, '0, 0, 32'h600);
        @(negedge clk);
        lit_read("post_flush", 0, 1, 1, 32'h666, 1);
        tick();

        // Randomised traffic over a key pool larger than the table.
        for (int n = 0; n < 1500; n++) begin
            flush = ($urandom_range(0, 99) < 3);
            drive(($urandom_range(0, 99) < 60), 32'h1000 + 32'($urandom_range(0, 5)) * 4,
                  $urandom, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 9) == 0) ? 32'h0
                                              : 32'h1000 + 32'($urandom_range(0, 5)) * 4);
            if (n == 700) begin
                // Asynchronous reset between edges must clear outputs immediately.
                #1;
                rst = 1'b0;
                model_clear();
                #1;
                lit_read("async_rst", 0, 0, 0, 32'h0, 0);
                lit_read("async_rst", 1, 0, 0, 32'h0, 0);
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        flush = 1'b0;
        drive(0, '0, '0, 0, '0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
